// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider
//  Description : Multi-cycle restoring divider (DIV/DIVU) feeding HI/LO.
//                Optional build macro DIV_ZERO_FAST_EN: a zero divisor skips
//                the iteration phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sign_en,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int               c_CNT_W = $clog2(WIDTH) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] c_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH+1:0] c_CIN   = {{(WIDTH+1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [WIDTH-1:0]   r_div;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_dividend_raw;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_dbz;
    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_div_by_zero;

    logic [WIDTH-1:0]   w_dividend_mag;
    logic [WIDTH-1:0]   w_divisor_mag;
    logic               w_divisor_zero;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH+1:0]   w_sum;
    logic               w_ge;

    // Most negative input maps to unsigned 2^(WIDTH-1), which fits the register.
    assign w_dividend_mag = (sign_en && dividend[WIDTH-1]) ? (~dividend + c_ONE) : dividend;
    assign w_divisor_mag  = (sign_en && divisor[WIDTH-1])  ? (~divisor + c_ONE)  : divisor;
    assign w_divisor_zero = (divisor == '0);

    // Trial subtract in ALU form: a + ~b + 1; carry out set means no borrow.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_sum   = {1'b0, w_shift} + {1'b0, ~{1'b0, r_div}} + c_CIN;
    // With no borrow the difference is below the divisor, so its top bit is clear.
    assign w_ge    = w_sum[WIDTH+1] & ~w_sum[WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
`ifdef DIV_ZERO_FAST_EN
                    w_next = w_divisor_zero ? S_FIX : S_RUN;
`else
                    w_next = S_RUN;
`endif
                end
            end
            S_RUN: begin
                if (r_cnt == c_LAST) begin
                    w_next = S_FIX;
                end
            end
            S_FIX:   w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div          <= '0;
            r_rem          <= '0;
            r_quo          <= '0;
            r_dividend_raw <= '0;
            r_cnt          <= '0;
            r_neg_q        <= 1'b0;
            r_neg_r        <= 1'b0;
            r_dbz          <= 1'b0;
            r_quotient     <= '0;
            r_remainder    <= '0;
            r_div_by_zero  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_div          <= w_divisor_mag;
                        r_quo          <= w_dividend_mag;
                        r_rem          <= '0;
                        r_dividend_raw <= dividend;
                        r_cnt          <= '0;
                        r_neg_q        <= sign_en & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        r_neg_r        <= sign_en & dividend[WIDTH-1];
                        r_dbz          <= w_divisor_zero;
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    r_quo <= {r_quo[WIDTH-2:0], w_ge};
                    r_rem <= w_ge ? w_sum[WIDTH-1:0] : w_shift[WIDTH-1:0];
                end
                S_FIX: begin
                    r_div_by_zero <= r_dbz;
                    if (r_dbz) begin
                        r_quotient  <= '1;
                        r_remainder <= r_dividend_raw;
                    end else begin
                        r_quotient  <= r_neg_q ? (~r_quo + c_ONE) : r_quo;
                        r_remainder <= r_neg_r ? (~r_rem + c_ONE) : r_rem;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy        = (r_state == S_RUN) || (r_state == S_FIX);
    assign done        = (r_state == S_DONE);
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_divider
//  Description : Randomized scoreboard bench for seq_divider.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

    localparam int W = 32;
`ifdef DIV_ZERO_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sign_en;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .sign_en     (sign_en),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           due;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] last_q = '0;
    logic [W-1:0] last_r = '0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Reference: plain 64-bit integer division truncating toward zero.
    function automatic exp_t model(bit s, logic [W-1:0] a, logic [W-1:0] b, int n);
        exp_t   e;
        longint sa;
        longint sbv;
        if (b == '0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
            e.due = n + (FAST ? 1 : W + 1);
        end else begin
            sa    = s ? longint'($signed(a)) : longint'({32'b0, a});
            sbv   = s ? longint'($signed(b)) : longint'({32'b0, b});
            e.q   = W'(sa / sbv);
            e.r   = W'(sa % sbv);
            e.dbz = 1'b0;
            e.due = n + W + 1;
        end
        return e;
    endfunction

    task automatic issue(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        @(negedge clk);
        while ((busy || done) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL idle_wait actual=busy required=idle (cycle %0d)", cyc);
            return;
        end
        check("held_quotient", {32'b0, quotient}, {32'b0, last_q});
        check("held_remainder", {32'b0, remainder}, {32'b0, last_r});
        start    = 1'b1;
        sign_en  = s;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        sb.push_back(model(s, a, b, cyc));
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    // Monitor: pops one expectation per done pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (done) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_done actual=1 required=0 (cycle %0d)", cyc);
                    end else begin
                        e = sb.pop_front();
                        check("quotient", {32'b0, quotient}, {32'b0, e.q});
                        check("remainder", {32'b0, remainder}, {32'b0, e.r});
                        check("div_by_zero", {63'b0, div_by_zero}, {63'b0, e.dbz});
                        check("done_cycle", 64'(cyc), 64'(e.due));
                        check("busy_at_done", {63'b0, busy}, 64'd0);
                        last_q = e.q;
                        last_r = e.r;
                    end
                end else if (sb.size() > 0) begin
                    check("busy_inflight", {63'b0, busy}, 64'd1);
                    if (cyc > sb[0].due) begin
                        checks++;
                        errors++;
                        $display("FAIL done_timeout actual=none required=cycle_%0d (cycle %0d)", sb[0].due, cyc);
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        int           n;
        bit           s;
        logic [W-1:0] a;
        logic [W-1:0] b;
        rst      = 1'b1;
        start    = 1'b0;
        sign_en  = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_quotient", {32'b0, quotient}, 64'd0);
        check("rst_remainder", {32'b0, remainder}, 64'd0);
        check("rst_dbz", {63'b0, div_by_zero}, 64'd0);
        rst = 1'b0;

        issue(1'b0, 32'd100, 32'd7);
        issue(1'b1, 32'hFFFF_FFF9, 32'd2);
        issue(1'b0, 32'hFFFF_FFF9, 32'd2);
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(1'b0, 32'd5, 32'd0);
        issue(1'b1, 32'hFFFF_FFF9, 32'd0);

        // A second start during a run must be dropped.
        issue(1'b0, 32'd1000, 32'd33);
        repeat (10) @(negedge clk);
        start    = 1'b1;
        sign_en  = 1'b1;
        dividend = 32'd77;
        divisor  = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;

        // Reset mid-run aborts without a done.
        issue(1'b0, 32'd12345, 32'd17);
        repeat (15) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        check("abort_busy", {63'b0, busy}, 64'd0);
        check("abort_done", {63'b0, done}, 64'd0);
        check("abort_quotient", {32'b0, quotient}, 64'd0);
        check("abort_remainder", {32'b0, remainder}, 64'd0);
        rst    = 1'b0;
        last_q = '0;
        last_r = '0;
        issue(1'b0, 32'd9, 32'd3);

        for (int i = 0; i < 24; i++) begin
            s = 1'($urandom_range(0, 1));
            a = (i % 7 == 3) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 4))
                0:       b = '0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = (i % 2 == 0) ? 32'hFFFF_FFFF : 32'h8000_0000;
                3:       b = 32'($urandom_range(1, 65535));
                default: b = $urandom;
            endcase
            issue(s, a, b);
        end

        n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain actual=%0d_pending required=0", sb.size());
        end
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
